// File: rtl/mips_pkg.sv
// Shared constants and the next-PC select encoding for the MIPS fetch path.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_4180;
  localparam logic [31:0] NOP_WORD_DFLT   = 32'h0000_0000;
  localparam logic [31:0] REGION_SIZE     = 32'h0000_1000;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_JMP  = 3'd2,
    NPC_EXC  = 3'd3,
    NPC_ERET = 3'd4,
    NPC_HOLD = 3'd5
  } npc_sel_e;

  // Unsigned subtract folds the lower and upper bound checks into one compare.
  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) < REGION_SIZE;
  endfunction

endpackage

// File: rtl/if_npc_sel.sv
// Combinational next-PC priority selector: exception, eret, stall, jump, branch, sequential.
module if_npc_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT
) (
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic        stall,
  input  logic        jmp,
  input  logic        br_taken,
  input  logic [31:0] pc,
  input  logic [31:0] epc,
  input  logic [31:0] jmp_target,
  input  logic [31:0] br_target,
  output npc_sel_e    sel,
  output logic [31:0] next_pc
);

  always_comb begin
    sel     = NPC_SEQ;
    next_pc = pc + 32'd4;
    if (exc_req) begin
      sel     = NPC_EXC;
      next_pc = EXC_VECTOR;
    end else if (eret_req) begin
      sel     = NPC_ERET;
      next_pc = epc;
    end else if (stall) begin
      sel     = NPC_HOLD;
      next_pc = pc;
    end else if (jmp) begin
      sel     = NPC_JMP;
      next_pc = jmp_target;
    end else if (br_taken) begin
      sel     = NPC_BR;
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, delay-slot tracking.
// Optional fetch-address fault checking is enabled with the IF_ADDR_CHECK_EN macro.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DFLT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_is_jb,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] im_dout,
  output logic [29:0] im_addr,
`ifdef IF_ADDR_CHECK_EN
  output logic        if_fault,
  output logic [31:0] if_fault_addr,
`endif
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc8,
  output logic        ifid_valid,
  output logic        ifid_bd
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc8_q, ipc8_d;
  logic        valid_q, valid_d;
  logic        bd_q, bd_d;
  npc_sel_e    sel;
  logic [31:0] next_pc;
  logic        flush;

  if_npc_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_npc_sel (
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .stall     (stall),
    .jmp       (jmp),
    .br_taken  (br_taken),
    .pc        (pc_q),
    .epc       (epc),
    .jmp_target(jmp_target),
    .br_target (br_target),
    .sel       (sel),
    .next_pc   (next_pc)
  );

  assign flush = (sel == NPC_EXC) || (sel == NPC_ERET);

`ifdef IF_ADDR_CHECK_EN
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        addr_bad;

  assign addr_bad = (pc_q[1:0] != 2'b00) ||
                    (!in_region(pc_q, RESET_PC) && !in_region(pc_q, EXC_VECTOR));
`endif

  always_comb begin
    pc_d    = next_pc;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc8_d  = ipc8_q;
    valid_d = valid_q;
    bd_d    = bd_q;
    if (flush) begin
      instr_d = NOP_WORD;
      ipc_d   = pc_q;
      ipc8_d  = pc_q + 32'd8;
      valid_d = 1'b0;
      bd_d    = 1'b0;
    end else if (sel != NPC_HOLD) begin
      // Branch/jump redirects keep the word fetched alongside them: it is the delay slot.
      instr_d = im_dout;
      ipc_d   = pc_q;
      ipc8_d  = pc_q + 32'd8;
      valid_d = 1'b1;
      bd_d    = id_is_jb;
    end
`ifdef IF_ADDR_CHECK_EN
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (exc_req) begin
      fault_d = 1'b0;
    end else begin
      if (fault_q) pc_d = pc_q;
      if (!flush && (sel != NPC_HOLD) && addr_bad) begin
        fault_d      = 1'b1;
        fault_addr_d = pc_q;
        instr_d      = NOP_WORD;
        valid_d      = 1'b0;
        bd_d         = 1'b0;
        pc_d         = pc_q;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      ipc_q   <= 32'd0;
      ipc8_q  <= 32'd8;
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc8_q  <= ipc8_d;
      valid_q <= valid_d;
      bd_q    <= bd_d;
    end
  end

`ifdef IF_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign if_fault      = fault_q;
  assign if_fault_addr = fault_addr_q;
`endif

  assign im_addr    = pc_q[31:2];
  assign ifid_instr = instr_q;
  assign ifid_pc    = ipc_q;
  assign ifid_pc8   = ipc8_q;
  assign ifid_valid = valid_q;
  assign ifid_bd    = bd_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, branch delay slot, stall, exception, eret.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, id_is_jb, br_taken, jmp, exc_req, eret_req;
  logic [31:0] br_target, jmp_target, epc, im_dout;
  logic [29:0] im_addr;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc8;
  logic        ifid_valid, ifid_bd;
`ifdef IF_ADDR_CHECK_EN
  logic        if_fault;
  logic [31:0] if_fault_addr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: distinct, nonzero word per address.
  function automatic logic [31:0] mw(input logic [31:0] pc);
    return {pc[31:2], 2'b11} ^ 32'h1234_0000;
  endfunction

  assign im_dout = mw({im_addr, 2'b00});

  if_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .id_is_jb  (id_is_jb),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .im_dout   (im_dout),
    .im_addr   (im_addr),
`ifdef IF_ADDR_CHECK_EN
    .if_fault     (if_fault),
    .if_fault_addr(if_fault_addr),
`endif
    .ifid_instr(ifid_instr),
    .ifid_pc   (ifid_pc),
    .ifid_pc8  (ifid_pc8),
    .ifid_valid(ifid_valid),
    .ifid_bd   (ifid_bd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc);
    chk({tag, ".im_addr"}, {2'b00, im_addr}, {2'b00, pc[31:2]});
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic bd);
    chk({tag, ".instr"}, ifid_instr, mw(pc));
    chk({tag, ".pc"}, ifid_pc, pc);
    chk({tag, ".pc8"}, ifid_pc8, pc + 32'd8);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'd1);
    chk({tag, ".bd"}, 32'(ifid_bd), 32'(bd));
  endtask

  task automatic chk_flush(input string tag, input logic [31:0] pc);
    chk({tag, ".instr"}, ifid_instr, 32'h0);
    chk({tag, ".pc"}, ifid_pc, pc);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'd0);
    chk({tag, ".bd"}, 32'(ifid_bd), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; id_is_jb = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    exc_req = 1'b0; eret_req = 1'b0;
    br_target = 32'h0; jmp_target = 32'h0; epc = 32'h0;

    // Reset for two cycles
    tick(); tick();
    chk_pc("rst", 32'h3000);
    chk("rst.instr", ifid_instr, 32'h0);
    chk("rst.pc", ifid_pc, 32'h0);
    chk("rst.pc8", ifid_pc8, 32'h8);
    chk("rst.valid", 32'(ifid_valid), 32'd0);
    chk("rst.bd", 32'(ifid_bd), 32'd0);
    rst_n = 1'b1;

    tick(); chk_ifid("seq0", 32'h3000, 1'b0); chk_pc("seq0", 32'h3004);
    tick(); chk_ifid("seq1", 32'h3004, 1'b0);
    tick(); chk_ifid("seq2", 32'h3008, 1'b0);
    tick(); chk_ifid("seq3", 32'h300C, 1'b0); chk_pc("seq3", 32'h3010);

    // Taken branch at pc=0x3010; its companion fetch is the delay slot
    id_is_jb = 1'b1; br_taken = 1'b1; br_target = 32'h3040;
    tick(); chk_ifid("br", 32'h3010, 1'b1); chk_pc("br", 32'h3040);
    id_is_jb = 1'b0; br_taken = 1'b0;
    tick(); chk_ifid("br_tgt", 32'h3040, 1'b0); chk_pc("br_tgt", 32'h3044);

    // Jump to 0x3020, then stall three cycles there
    jmp = 1'b1; jmp_target = 32'h3020;
    tick(); chk_ifid("jmp", 32'h3044, 1'b0); chk_pc("jmp", 32'h3020);
    jmp = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_ifid("stall", 32'h3044, 1'b0); chk_pc("stall", 32'h3020);
    end
    stall = 1'b0;
    tick(); chk_ifid("resume", 32'h3020, 1'b0); chk_pc("resume", 32'h3024);
    tick(); chk_ifid("seq4", 32'h3024, 1'b0); chk_pc("seq4", 32'h3028);

    // Exception overrides stall
    stall = 1'b1; exc_req = 1'b1;
    tick(); chk_flush("exc", 32'h3028); chk_pc("exc", 32'h4180);
    stall = 1'b0; exc_req = 1'b0;
    tick(); chk_ifid("hdl0", 32'h4180, 1'b0);
    tick(); chk_ifid("hdl1", 32'h4184, 1'b0);
    tick(); chk_ifid("hdl2", 32'h4188, 1'b0);
    tick(); chk_ifid("hdl3", 32'h418C, 1'b0); chk_pc("hdl3", 32'h4190);

    // Eret back to EPC
    epc = 32'h302C; eret_req = 1'b1;
    tick(); chk_flush("eret", 32'h4190); chk_pc("eret", 32'h302C);
    eret_req = 1'b0;
    tick(); chk_ifid("eret_tgt", 32'h302C, 1'b0); chk_pc("eret_tgt", 32'h3030);

    // Exception beats eret
    eret_req = 1'b1; exc_req = 1'b1;
    tick(); chk_flush("exc_eret", 32'h3030); chk_pc("exc_eret", 32'h4180);
    eret_req = 1'b0; exc_req = 1'b0;

    // Jump beats branch
    jmp = 1'b1; jmp_target = 32'h3100; br_taken = 1'b1; br_target = 32'h3200;
    tick(); chk_ifid("jmp_br", 32'h4180, 1'b0); chk_pc("jmp_br", 32'h3100);
    jmp = 1'b0; br_taken = 1'b0;

    // Reset mid-redirect discards the redirect
    rst_n = 1'b0; jmp = 1'b1; jmp_target = 32'h3300;
    tick(); chk_pc("rst_jmp", 32'h3000);
    chk("rst_jmp.valid", 32'(ifid_valid), 32'd0);
    chk("rst_jmp.pc", ifid_pc, 32'h0);
    rst_n = 1'b1; jmp = 1'b0;
    tick(); chk_ifid("rst_seq", 32'h3000, 1'b0); chk_pc("rst_seq", 32'h3004);

`ifdef IF_ADDR_CHECK_EN
    // Misaligned jump target faults and holds the PC until an exception
    jmp = 1'b1; jmp_target = 32'h3002;
    tick(); chk_ifid("fj", 32'h3004, 1'b0); chk_pc("fj", 32'h3002);
    jmp = 1'b0;
    tick();
    chk("fault", 32'(if_fault), 32'd1);
    chk("fault.addr", if_fault_addr, 32'h3002);
    chk("fault.valid", 32'(ifid_valid), 32'd0);
    chk("fault.instr", ifid_instr, 32'h0);
    chk_pc("fault", 32'h3002);
    tick();
    chk("fault_hold", 32'(if_fault), 32'd1);
    chk_pc("fault_hold", 32'h3002);
    exc_req = 1'b1;
    tick();
    chk("fault_clr", 32'(if_fault), 32'd0);
    chk_pc("fault_clr", 32'h4180);
    exc_req = 1'b0;
`else
    // Unchecked build: wrap of pc+8 and pc+4 at the top of the address space
    jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    tick(); chk_ifid("wj", 32'h3004, 1'b0); chk_pc("wj", 32'hFFFF_FFFC);
    jmp = 1'b0;
    tick();
    chk("wrap.pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap.pc8", ifid_pc8, 32'h0000_0004);
    chk("wrap.instr", ifid_instr, mw(32'hFFFF_FFFC));
    chk_pc("wrap", 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
